// File: rtl/leb128_encoder_pkg.sv
// Shared definitions for the LEB128 encoder: value type codes, FSM states and
// encoding constants used by the encoder, its termination helper and benches.
package leb128_encoder_pkg;

    localparam int LEB128_DW        = 64;
    localparam int LEB128_MAX_BYTES = 10;
    localparam logic [7:0] LEB128_CONT = 8'h80;

    // Operand type codes; any code other than LEB_I32 is encoded as i64.
    localparam logic [1:0] LEB_I32 = 2'b00;
    localparam logic [1:0] LEB_I64 = 2'b01;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_EMIT = 1'b1
    } state_t;

    function automatic logic is_i32(input logic [1:0] code);
        return code == LEB_I32;
    endfunction

endpackage

// File: rtl/leb128_term.sv
// LEB128 termination rule: splits the shift register into the next 7-bit group
// and the remainder, and flags whether the current group is the final byte.
module leb128_term #(
    parameter int DW = 64
) (
    input  logic [DW-1:0] sr,
    input  logic          sgn,
    output logic [6:0]    low7,
    output logic [DW-1:0] rest,
    output logic          done
);

    always_comb begin
        // NOTE: every output gets a value on every path, so no latch is inferred.
        low7 = sr[6:0];
        rest = sgn ? $unsigned($signed(sr) >>> 7) : (sr >> 7);
        if (sgn)
            done = ((rest == '0) && !sr[6]) || ((rest == '1) && sr[6]);
        else
            done = (rest == '0);
    end

endmodule

// File: rtl/leb128_encoder.sv
// Serialises one i32/i64 value per transaction into an unsigned or signed
// LEB128 byte stream with valid/ready handshakes on both sides.
module leb128_encoder
    import leb128_encoder_pkg::*;
#(
    parameter int DW        = LEB128_DW,
    parameter int MAX_BYTES = LEB128_MAX_BYTES
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_value,
    input  logic [1:0]    in_type,
    input  logic          in_signed,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [7:0]    out_data,
    output logic          out_last,
    output logic [3:0]    out_count
);

    state_t          state;
    logic [DW-1:0]   sr;
    logic [DW-1:0]   load;
    logic [DW-1:0]   rest;
    logic [6:0]      low7;
    logic            sgn;
    logic            done;
    logic [3:0]      cnt;

    leb128_term #(.DW(DW)) u_term (
        .sr   (sr),
        .sgn  (sgn),
        .low7 (low7),
        .rest (rest),
        .done (done)
    );

    // i32 operands ignore the upper half of in_value and are re-extended here.
    always_comb begin
        load = in_value;
        if (is_i32(in_type))
            load = in_signed ? {{(DW-32){in_value[31]}}, in_value[31:0]}
                             : {{(DW-32){1'b0}},        in_value[31:0]};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            sr        <= '0;
            sgn       <= 1'b0;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of its neighbours.
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        sr        <= load;
                        sgn       <= in_signed;
                        cnt       <= 4'd1;
                        in_ready  <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (out_ready) begin
                        if (done) begin
                            sr        <= '0;
                            cnt       <= '0;
                            in_ready  <= 1'b1;
                            out_valid <= 1'b0;
                            state     <= S_IDLE;
                        end else begin
                            sr  <= rest;
                            cnt <= cnt + 4'd1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Byte outputs are gated by out_valid so the idle bus reads all zeros.
    assign out_data  = out_valid ? ((done ? 8'h00 : LEB128_CONT) | {1'b0, low7}) : 8'h00;
    assign out_last  = out_valid & done;
    assign out_count = cnt;

    a_count_bound: assert property (@(posedge clk) disable iff (!reset)
        cnt <= 4'(MAX_BYTES));

endmodule
